reg_wb_arbiter: RTL
===================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as in the codebase: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-low reset).
REQ-002 alu_valid  input  1  ALU result offered for write-back.
REQ-003 alu_rd  input  4  ALU destination register.
REQ-004 alu_data  input  32  ALU result value.
REQ-005 alu_ready  output  1  ALU offer accepted this cycle.
REQ-006 mem_valid / mem_rd / mem_data  input  1/4/32  load-unit offer, same meaning as the ALU signals.
REQ-007 mem_ready  output  1  load offer accepted this cycle.
REQ-008 iss_en  input  1  decode reserves a destination register.
REQ-009 iss_rd  input  4  destination register being reserved.
REQ-010 chk_rs / chk_rt  input  4/4  decode source registers to hazard-check.
REQ-011 stall  output  1  decode must hold this cycle.
REQ-012 wb_en / wb_rd / wb_data  output  1/4/32  register-file write port (drives RdEnIn/RdIn/Result).
REQ-013 byp_rs / byp_rt  output  1/1  source operand to be taken from wb_data.
REQ-014 err  output  1  sticky flag: write-back to a register that was not reserved.

Function
REQ-015 At most one offer SHALL be accepted per cycle. A requester's ready is high only in the cycle its offer is granted (combinational from the valid signals and the last_grant flop).
REQ-016 Arbitration SHALL be round-robin. If both requesters are valid, grant the one not granted last. If only one is valid, grant it. last_grant updates only on a grant.
REQ-017 A grant in cycle N SHALL present wb_en=1, wb_rd, wb_data in cycle N+1 (registered, one-cycle latency). With no grant, wb_en=0 and wb_rd/wb_data hold their previous values.
REQ-018 A grant with rd=0 SHALL be accepted with wb_en=0 in N+1 (R0 is never written).
REQ-019 The scoreboard SHALL hold 15 pending bits (R1..R15). R0 is never pending.
REQ-020 Set: iss_en=1, stall=0, iss_rd!=0 sets pending[iss_rd] at the clock edge. iss_en while stall=1 is ignored.
REQ-021 Clear: wb_en=1 clears pending[wb_rd] at the edge ending that cycle.
REQ-022 If a set and a clear target the same register on the same edge, the set SHALL win.
REQ-023 stall = (chk_rs pending) | (chk_rt pending) | (iss_en & iss_rd pending), combinational. This is subject to REQ-030.
REQ-024 If wb_en=1 and pending[wb_rd]=0 (with wb_rd!=0), err SHALL set and hold until reset.
REQ-025 Hazard timing: with a grant in N, a dependent source is seen as free no earlier than N+2 (without bypass).

Reset
REQ-026 Reset (rst=0 at a rising edge) SHALL clear all pending bits, last_grant (meaning MEM was last, so ALU wins first tie), wb_en, wb_rd, wb_data and err.
REQ-027 Reset in the middle of operation SHALL discard any grant made in that cycle. wb_en=0 in the following cycle.
REQ-028 During reset, alu_ready, mem_ready, stall, byp_rs and byp_rt SHALL be 0.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL select the bypass feature.
REQ-030 With WB_BYPASS_EN defined: a source equal to wb_rd while wb_en=1 does not cause a stall. byp_rs/byp_rt assert for that source (a dependent is released in N+1).
REQ-031 With WB_BYPASS_EN undefined: byp_rs=byp_rt=0 constantly, and stall follows REQ-023 with no exemption.

Verification
REQ-032 Reset, then alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF with R3 issued earlier -> alu_ready=1 in N, then wb_en=1, wb_rd=3, wb_data=0xDEADBEEF in N+1, pending[3] clear in N+2.
REQ-033 Both requesters valid for 4 cycles -> grants alternate ALU, MEM, ALU, MEM. Never both ready in one cycle.
REQ-034 Issue rd=5, then chk_rs=5 -> stall=1 until write-back of R5. Without the macro, stall=0 first in N+2. With WB_BYPASS_EN, stall=0 and byp_rs=1 in N+1.
REQ-035 mem write-back to rd=7 with no prior issue -> err=1 and held until rst=0. Write-back with rd=0 -> wb_en=0, err stays 0.
REQ-036 rst=0 asserted in the same cycle as a grant -> wb_en=0 next cycle, all pending bits and err cleared.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin ALU/load write-back arbiter with a register scoreboard.
// Defining WB_BYPASS_EN lets a source matching the live write port bypass instead of stall.
module reg_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        iss_en,
  input  logic [3:0]  iss_rd,
  input  logic [3:0]  chk_rs,
  input  logic [3:0]  chk_rt,
  output logic        stall,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        byp_rs,
  output logic        byp_rt,
  output logic        err
);

  // last_mem_r=1 means the load unit won the previous grant.
  logic        last_mem_r;
  logic [15:0] pending_r;
  logic        wb_en_r;
  logic [3:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        err_r;

  logic        alu_gnt_s;
  logic        mem_gnt_s;
  logic [3:0]  gnt_rd_s;
  logic [31:0] gnt_data_s;
  logic        rs_fwd_s;
  logic        rt_fwd_s;
  logic        rs_hit_s;
  logic        rt_hit_s;
  logic        iss_hit_s;
  logic        stall_s;
  logic        iss_set_s;
  logic [15:0] clr_mask_s;
  logic [15:0] set_mask_s;
  logic [15:0] pend_nxt_s;
  logic        err_nxt_s;

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    alu_gnt_s = 1'b0;
    mem_gnt_s = 1'b0;
    if (!rst) begin
      alu_gnt_s = 1'b0;
      mem_gnt_s = 1'b0;
    end else if (alu_valid && mem_valid) begin
      alu_gnt_s = last_mem_r;
      mem_gnt_s = ~last_mem_r;
    end else begin
      alu_gnt_s = alu_valid;
      mem_gnt_s = mem_valid;
    end
  end

  // Select the granted requester's destination and value for the write port.
  always_comb begin
    gnt_rd_s   = alu_rd;
    gnt_data_s = alu_data;
    if (mem_gnt_s) begin
      gnt_rd_s   = mem_rd;
      gnt_data_s = mem_data;
    end else begin
      gnt_rd_s   = alu_rd;
      gnt_data_s = alu_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs_fwd_s = wb_en_r & (chk_rs == wb_rd_r);
  assign rt_fwd_s = wb_en_r & (chk_rt == wb_rd_r);
`else
  assign rs_fwd_s = 1'b0;
  assign rt_fwd_s = 1'b0;
`endif

  // Hazard detection: a pending source holds decode unless it is being forwarded.
  always_comb begin
    rs_hit_s  = pending_r[chk_rs] & ~rs_fwd_s;
    rt_hit_s  = pending_r[chk_rt] & ~rt_fwd_s;
    iss_hit_s = iss_en & pending_r[iss_rd];
    if (rst) begin
      stall_s = rs_hit_s | rt_hit_s | iss_hit_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Set is applied after clear so a same-edge set of the same register wins.
  assign iss_set_s  = iss_en & ~stall_s & (iss_rd != 4'd0);
  assign clr_mask_s = wb_en_r   ? (16'd1 << wb_rd_r) : 16'd0;
  assign set_mask_s = iss_set_s ? (16'd1 << iss_rd)  : 16'd0;
  assign pend_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 16'hFFFE;
  assign err_nxt_s  = err_r | (wb_en_r & ~pending_r[wb_rd_r]);

  // Write-port register and round-robin history; R0 grants are consumed silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_mem_r <= 1'b1;
      wb_en_r    <= 1'b0;
      wb_rd_r    <= 4'd0;
      wb_data_r  <= 32'd0;
    end else if (alu_gnt_s || mem_gnt_s) begin
      last_mem_r <= mem_gnt_s;
      wb_en_r    <= (gnt_rd_s != 4'd0);
      wb_rd_r    <= gnt_rd_s;
      wb_data_r  <= gnt_data_s;
    end else begin
      wb_en_r    <= 1'b0;
    end
  end

  // Scoreboard and sticky unreserved-write flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      pending_r <= pend_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign alu_ready = alu_gnt_s;
  assign mem_ready = mem_gnt_s;
  assign stall     = stall_s;
  assign byp_rs    = rst & rs_fwd_s;
  assign byp_rt    = rst & rt_fwd_s;
  assign wb_en     = wb_en_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign err       = err_r;

endmodule
